// File: rtl/dbg_bus_bridge_pkg.sv
// dbg_bus_bridge_pkg
//   Shared definitions for the debug bus bridge: FSM state encoding,
//   frame command/response byte values, bus widths and a small state
//   classification helper.
package dbg_bus_bridge_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR_HI  = 4'd1,
    ST_ADDR_LO  = 4'd2,
    ST_DATA_HI  = 4'd3,
    ST_DATA_LO  = 4'd4,
    ST_BUS_WAIT = 4'd5,
    ST_BUS_ACC  = 4'd6,
    ST_TX_HI    = 4'd7,
    ST_TX_LO    = 4'd8
  } state_t;

  // True in the states that are waiting for the next byte of a frame;
  // only these are subject to the inter-byte timeout.
  function automatic logic is_collect_state(state_t s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

endpackage

// File: rtl/dbg_bus_bridge_byte_timeout_counter.sv
// dbg_bus_bridge_byte_timeout_counter
//   Counts idle cycles between received bytes and flags expiry once the
//   count reaches TIMEOUT. The count saturates at TIMEOUT and is held at
//   zero whenever the counter is not enabled.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clear       : restart the count (byte received / frame start)
//   i_enable      : count while high
//   o_expired     : enabled and count has reached TIMEOUT
module dbg_bus_bridge_byte_timeout_counter
  import dbg_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_enable) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_enable && (cnt_q == LIMIT);

endmodule

// File: rtl/dbg_bus_bridge.sv
// dbg_bus_bridge
//   Turns byte frames from a serial receiver into single accesses on a
//   shared memory bus and returns a response byte stream.
//   Frame: CMD, ADDR_HI, ADDR_LO [, DATA_HI, DATA_LO for writes].
//   Write -> ACK byte; read -> data high byte then low byte;
//   unknown command -> error byte, no bus activity.
// Ports:
//   i_clk, i_rstn            : clock, asynchronous active-low reset
//   i_rxByte, i_rxValid      : received byte and its one-cycle strobe
//   o_txByte, o_txValid,
//   i_txReady                : response byte, valid/ready handshake
//   o_busReq, i_busGrant     : bus ownership request / grant
//   o_memAddr, o_memDataOut,
//   o_memWrEn, o_memRdEn,
//   i_memDataIn              : memory bus access signals
//   o_busy                   : a frame is being handled
// All outputs are registered.
module dbg_bus_bridge
  import dbg_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [7:0]        i_rxByte,
  input  logic              i_rxValid,
  output logic [7:0]        o_txByte,
  output logic              o_txValid,
  input  logic              i_txReady,
  output logic              o_busReq,
  input  logic              i_busGrant,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memDataOut,
  output logic              o_memWrEn,
  output logic              o_memRdEn,
  input  logic [DATA_W-1:0] i_memDataIn,
  output logic              o_busy
);

  state_t              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_valid_q, tx_valid_d;
  logic                bus_req_q, bus_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_out_q, mem_data_out_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic                busy_q, busy_d;

  logic                timeout_clear;
  logic                timeout_expired;

  // Count restarts on any received byte and on frame start.
  assign timeout_clear = i_rxValid ||
                         ((state_d == ST_ADDR_HI) && (state_q != ST_ADDR_HI));

  dbg_bus_bridge_byte_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clear   (timeout_clear),
    .i_enable  (is_collect_state(state_q)),
    .o_expired (timeout_expired)
  );

  always_comb begin
    state_d        = state_q;
    is_wr_d        = is_wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_data_d      = rd_data_q;
    tx_byte_d      = tx_byte_q;
    tx_valid_d     = tx_valid_q;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    mem_wr_en_d    = 1'b0;
    mem_rd_en_d    = 1'b0;

    // Byte reception always takes priority over timeout expiry.
    unique case (state_q)
      ST_IDLE: begin
        // A queued error byte drains while idle.
        if (tx_valid_q && i_txReady) tx_valid_d = 1'b0;
        if (i_rxValid) begin
          if (i_rxByte == CMD_WR || i_rxByte == CMD_RD) begin
            is_wr_d = (i_rxByte == CMD_WR);
            state_d = ST_ADDR_HI;
          end else begin
            tx_byte_d  = RSP_ERR;
            tx_valid_d = 1'b1;
          end
        end
      end
      ST_ADDR_HI: begin
        if (i_rxValid) begin
          addr_d[ADDR_W-1:8] = i_rxByte[ADDR_W-9:0];
          state_d            = ST_ADDR_LO;
        end else if (timeout_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_LO: begin
        if (i_rxValid) begin
          addr_d[7:0] = i_rxByte;
          state_d     = is_wr_q ? ST_DATA_HI : ST_BUS_WAIT;
        end else if (timeout_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_HI: begin
        if (i_rxValid) begin
          wdata_d[15:8] = i_rxByte;
          state_d       = ST_DATA_LO;
        end else if (timeout_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_LO: begin
        if (i_rxValid) begin
          wdata_d[7:0] = i_rxByte;
          state_d      = ST_BUS_WAIT;
        end else if (timeout_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS_WAIT: begin
        // Bus outputs are loaded only here so they hold between accesses.
        if (i_busGrant) begin
          state_d     = ST_BUS_ACC;
          mem_addr_d  = addr_q;
          mem_wr_en_d = is_wr_q;
          mem_rd_en_d = !is_wr_q;
          if (is_wr_q) mem_data_out_d = wdata_q;
        end
      end
      ST_BUS_ACC: begin
        tx_valid_d = 1'b1;
        if (is_wr_q) begin
          tx_byte_d = RSP_ACK;
          state_d   = ST_TX_LO;
        end else begin
          // Read data is sampled on the closing edge of the access cycle.
          rd_data_d = i_memDataIn;
          tx_byte_d = i_memDataIn[15:8];
          state_d   = ST_TX_HI;
        end
      end
      ST_TX_HI: begin
        if (tx_valid_q && i_txReady) begin
          tx_byte_d = rd_data_q[7:0];
          state_d   = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        if (tx_valid_q && i_txReady) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    bus_req_d = (state_d == ST_BUS_WAIT) || (state_d == ST_BUS_ACC);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q        <= ST_IDLE;
      is_wr_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_data_q      <= '0;
      tx_byte_q      <= '0;
      tx_valid_q     <= 1'b0;
      bus_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      mem_wr_en_q    <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_wr_q        <= is_wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_data_q      <= rd_data_d;
      tx_byte_q      <= tx_byte_d;
      tx_valid_q     <= tx_valid_d;
      bus_req_q      <= bus_req_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem_rd_en_q    <= mem_rd_en_d;
      busy_q         <= busy_d;
    end
  end

  assign o_txByte     = tx_byte_q;
  assign o_txValid    = tx_valid_q;
  assign o_busReq     = bus_req_q;
  assign o_memAddr    = mem_addr_q;
  assign o_memDataOut = mem_data_out_q;
  assign o_memWrEn    = mem_wr_en_q;
  assign o_memRdEn    = mem_rd_en_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// tb_dbg_bus_bridge
//   Directed bench for dbg_bus_bridge: a table of whole frames with their
//   expected bus activity and response bytes, plus hand-written sequences
//   for response back-pressure, inter-byte timeout and reset mid-access.
module tb_dbg_bus_bridge;

  localparam int TO = 20;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [7:0]  i_rxByte;
  logic        i_rxValid;
  logic [7:0]  o_txByte;
  logic        o_txValid;
  logic        i_txReady;
  logic        o_busReq;
  logic        i_busGrant = 1'b0;
  logic [13:0] o_memAddr;
  logic [15:0] o_memDataOut;
  logic        o_memWrEn;
  logic        o_memRdEn;
  logic [15:0] i_memDataIn;
  logic        o_busy;

  logic [15:0] rd_value = 16'h0000;
  int          grant_delay = 0;
  int          req_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state (written only by the monitor process)
  int          mon_req  = 0;
  int          mon_wr   = 0;
  int          mon_rd   = 0;
  int          mon_both = 0;
  logic [13:0] mon_addr = '0;
  logic [15:0] mon_wd   = '0;
  logic [7:0]  txq[$];

  always #5 i_clk = ~i_clk;

  // Responder drives known data only during a read strobe.
  assign i_memDataIn = o_memRdEn ? rd_value : 16'hDEAD;

  dbg_bus_bridge #(.TIMEOUT(TO)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_rxByte     (i_rxByte),
    .i_rxValid    (i_rxValid),
    .o_txByte     (o_txByte),
    .o_txValid    (o_txValid),
    .i_txReady    (i_txReady),
    .o_busReq     (o_busReq),
    .i_busGrant   (i_busGrant),
    .o_memAddr    (o_memAddr),
    .o_memDataOut (o_memDataOut),
    .o_memWrEn    (o_memWrEn),
    .o_memRdEn    (o_memRdEn),
    .i_memDataIn  (i_memDataIn),
    .o_busy       (o_busy)
  );

  // Arbiter model: grant once the request has been seen for grant_delay cycles.
  always @(posedge i_clk) begin
    #1;
    if (o_busReq) begin
      i_busGrant = (req_cnt >= grant_delay);
      req_cnt++;
    end else begin
      i_busGrant = 1'b0;
      req_cnt = 0;
    end
  end

  always @(negedge i_clk) begin
    if (o_busReq) mon_req++;
    if (o_memWrEn) mon_wr++;
    if (o_memRdEn) mon_rd++;
    if (o_memWrEn && o_memRdEn) mon_both++;
    if (o_memWrEn || o_memRdEn) begin
      mon_addr = o_memAddr;
      mon_wd   = o_memDataOut;
    end
    if (o_txValid && i_txReady) txq.push_back(o_txByte);
  end

  typedef struct {
    logic [39:0] bytes;
    int          n;
    int          gdly;
    logic [15:0] rdv;
    int          exp_wr;
    int          exp_rd;
    logic [13:0] exp_addr;
    logic [15:0] exp_wd;
    int          exp_req;
    int          exp_ntx;
    logic [15:0] exp_tx;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(logic [39:0] b, int n, int g, logic [15:0] rdv,
                              int wr, int rd, logic [13:0] a, logic [15:0] wd,
                              int req, int ntx, logic [15:0] tx);
    vec_t v;
    v.bytes = b; v.n = n; v.gdly = g; v.rdv = rdv;
    v.exp_wr = wr; v.exp_rd = rd; v.exp_addr = a; v.exp_wd = wd;
    v.exp_req = req; v.exp_ntx = ntx; v.exp_tx = tx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rxValid = 1'b1;
    i_rxByte  = b;
    @(posedge i_clk); #1;
    i_rxValid = 1'b0;
  endtask

  task automatic wait_idle(input int t0, input int need_tx, output bit done);
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (!o_busy && !o_txValid && (txq.size() - t0) >= need_tx) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int w0, r0, q0, t0;
    bit done;
    w0 = mon_wr; r0 = mon_rd; q0 = mon_req; t0 = txq.size();
    grant_delay = v.gdly;
    rd_value    = v.rdv;
    for (int i = 0; i < v.n; i++) send_byte(v.bytes[39-8*i -: 8]);
    wait_idle(t0, v.exp_ntx, done);
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " wr_strobes"}, 32'(mon_wr - w0), 32'(v.exp_wr));
    chk({nm, " rd_strobes"}, 32'(mon_rd - r0), 32'(v.exp_rd));
    chk({nm, " busreq_cycles"}, 32'(mon_req - q0), 32'(v.exp_req));
    chk({nm, " tx_count"}, 32'(txq.size() - t0), 32'(v.exp_ntx));
    if (v.exp_wr + v.exp_rd > 0) begin
      chk({nm, " strobe_addr"}, 32'(mon_addr), 32'(v.exp_addr));
      chk({nm, " strobe_data_out"}, 32'(mon_wd), 32'(v.exp_wd));
      chk({nm, " addr_held"}, 32'(o_memAddr), 32'(v.exp_addr));
    end
    for (int k = 0; k < v.exp_ntx; k++) begin
      if (t0 + k < txq.size())
        chk({nm, " tx_byte"}, 32'(txq[t0+k]), 32'(v.exp_tx[15-8*k -: 8]));
    end
    $display("frame %s: wr=%0d rd=%0d req=%0d addr=%h dout=%h tx=%0d", nm,
             mon_wr - w0, mon_rd - r0, mon_req - q0, mon_addr, mon_wd, txq.size() - t0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w0, r0, q0, t0, busy_cycles;
    bit   done, found, fell, stable;
    logic [7:0] hold;

    vecs[0] = mk(40'h57_00_04_AB_CD, 5, 0, 16'h0000, 1, 0, 14'h0004, 16'hABCD, 2, 1, 16'h4B00);
    vecs[1] = mk(40'h52_C0_10_00_00, 3, 4, 16'h1234, 0, 1, 14'h0010, 16'hABCD, 6, 2, 16'h1234);
    vecs[2] = mk(40'h41_00_00_00_00, 1, 0, 16'h0000, 0, 0, 14'h0000, 16'h0000, 0, 1, 16'h3F00);
    vecs[3] = mk(40'h57_FF_FF_00_01, 5, 1, 16'h0000, 1, 0, 14'h3FFF, 16'h0001, 3, 1, 16'h4B00);
    vecs[4] = mk(40'h52_3F_00_00_00, 3, 0, 16'hA55A, 0, 1, 14'h3F00, 16'h0001, 2, 2, 16'hA55A);
    vecs[5] = mk(40'h00_00_00_00_00, 1, 0, 16'h0000, 0, 0, 14'h0000, 16'h0000, 0, 1, 16'h3F00);

    i_rstn = 1'b0; i_rxByte = 8'h00; i_rxValid = 1'b0; i_txReady = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("reset txValid", 32'(o_txValid), 32'd0);
    chk("reset txByte", 32'(o_txByte), 32'd0);
    chk("reset busReq", 32'(o_busReq), 32'd0);
    chk("reset memAddr", 32'(o_memAddr), 32'd0);
    chk("reset memDataOut", 32'(o_memDataOut), 32'd0);
    chk("reset strobes", 32'({o_memWrEn, o_memRdEn}), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Response back-pressure; a byte arriving during TX is dropped.
    w0 = mon_wr; r0 = mon_rd; t0 = txq.size();
    i_txReady = 1'b0; grant_delay = 0; rd_value = 16'hBEEF;
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_txValid) begin found = 1'b1; break; end
    end
    chk("stall tx_appears", 32'(found), 32'd1);
    hold = o_txByte;
    chk("stall first_byte", 32'(hold), 32'hBE);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      i_rxValid = (k == 3);
      i_rxByte  = 8'h57;
      @(negedge i_clk);
      if (o_txByte !== hold || o_txValid !== 1'b1) stable = 1'b0;
    end
    chk("stall byte_stable", 32'(stable), 32'd1);
    @(posedge i_clk); #1;
    i_rxValid = 1'b0; i_txReady = 1'b1;
    wait_idle(t0, 2, done);
    chk("stall done", 32'(done), 32'd1);
    chk("stall tx_count", 32'(txq.size() - t0), 32'd2);
    if (txq.size() - t0 == 2) begin
      chk("stall tx0", 32'(txq[t0]), 32'hBE);
      chk("stall tx1", 32'(txq[t0+1]), 32'hEF);
    end
    chk("stall rd_strobes", 32'(mon_rd - r0), 32'd1);
    chk("stall wr_strobes", 32'(mon_wr - w0), 32'd0);
    chk("stall addr", 32'(mon_addr), 32'h0123);
    repeat (3) @(negedge i_clk);
    chk("stall dropped_byte_busy", 32'(o_busy), 32'd0);
    $display("stall read: tx=%0d bytes, dropped extra byte", txq.size() - t0);

    // Inter-byte timeout abandons the frame silently.
    w0 = mon_wr; r0 = mon_rd; q0 = mon_req; t0 = txq.size();
    send_byte(8'h57); send_byte(8'h00);
    busy_cycles = 0; fell = 1'b0;
    for (int c = 0; c < 3 * TO; c++) begin
      @(negedge i_clk);
      if (o_busy) busy_cycles++;
      else begin fell = 1'b1; break; end
    end
    chk("timeout busy_fell", 32'(fell), 32'd1);
    chk("timeout busy_cycles", 32'(busy_cycles), 32'(TO + 1));
    repeat (3) @(negedge i_clk);
    chk("timeout no_tx", 32'(txq.size() - t0), 32'd0);
    chk("timeout no_txValid", 32'(o_txValid), 32'd0);
    chk("timeout no_bus", 32'((mon_wr - w0) + (mon_rd - r0) + (mon_req - q0)), 32'd0);
    $display("timeout: busy held %0d cycles after last byte", busy_cycles);

    run_vec("after_timeout", mk(40'h52_00_00_00_00, 3, 0, 16'h0F0F, 0, 1,
                                14'h0000, 16'h0001, 2, 2, 16'h0F0F));

    // A byte in the very cycle the timeout expires still advances the frame.
    w0 = mon_wr; t0 = txq.size(); grant_delay = 0;
    send_byte(8'h57); send_byte(8'h00);
    repeat (TO) @(posedge i_clk);
    #1;
    i_rxValid = 1'b1; i_rxByte = 8'h12;
    @(posedge i_clk); #1;
    i_rxValid = 1'b0;
    @(negedge i_clk);
    chk("race busy_after_late_byte", 32'(o_busy), 32'd1);
    send_byte(8'h34); send_byte(8'h56);
    wait_idle(t0, 1, done);
    chk("race done", 32'(done), 32'd1);
    chk("race wr_strobes", 32'(mon_wr - w0), 32'd1);
    chk("race addr", 32'(mon_addr), 32'h0012);
    chk("race data", 32'(mon_wd), 32'h3456);
    if (txq.size() > t0) chk("race tx", 32'(txq[t0]), 32'h4B);
    $display("race: late byte accepted, addr=%h data=%h", mon_addr, mon_wd);

    // Reset asserted while waiting for the bus.
    grant_delay = 1000;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_busReq) begin found = 1'b1; break; end
    end
    chk("rst_wait reached_bus_wait", 32'(found), 32'd1);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("rst_async busReq", 32'(o_busReq), 32'd0);
    chk("rst_async busy", 32'(o_busy), 32'd0);
    chk("rst_async memAddr", 32'(o_memAddr), 32'd0);
    chk("rst_async memDataOut", 32'(o_memDataOut), 32'd0);
    chk("rst_async txByte", 32'(o_txByte), 32'd0);
    chk("rst_async txValid_strobes", 32'({o_txValid, o_memWrEn, o_memRdEn}), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    grant_delay = 0;
    i_rstn = 1'b1;
    w0 = mon_wr; r0 = mon_rd; q0 = mon_req; t0 = txq.size();
    repeat (20) @(negedge i_clk);
    chk("rst_after no_strobe", 32'((mon_wr - w0) + (mon_rd - r0)), 32'd0);
    chk("rst_after no_busreq", 32'(mon_req - q0), 32'd0);
    chk("rst_after no_tx", 32'(txq.size() - t0), 32'd0);
    chk("rst_after busy", 32'(o_busy), 32'd0);
    chk("never_both_strobes", 32'(mon_both), 32'd0);
    $display("reset in bus wait: frame abandoned");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_bus_bridge.md
DBG_BUS_BRIDGE -- requirements
Module: dbg_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 50000, is the maximum idle cycles between bytes of one frame.
REQ-002 The ports SHALL be:
- i_clk  in  1  sole clock; all state on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_rxByte  in  8  received serial byte
- i_rxValid  in  1  one-cycle strobe; i_rxByte valid
- o_txByte  out  8  response byte
- o_txValid  out  1  response byte pending
- i_txReady  in  1  consumer accepts o_txByte this cycle
- o_busReq  out  1  request ownership of memory bus
- i_busGrant  in  1  ownership granted
- o_memAddr  out  14  bus address
- o_memDataOut  out  16  bus write data
- o_memWrEn  out  1  write strobe
- o_memRdEn  out  1  read strobe
- i_memDataIn  in  16  bus read data, combinational from responder
- o_busy  out  1  frame in progress (state != IDLE)

Function
REQ-003 Frame format: CMD, ADDR_HI, ADDR_LO, then DATA_HI, DATA_LO for writes only; address = {ADDR_HI[5:0], ADDR_LO}, ADDR_HI[7:6] ignored.
REQ-004 CMD 0x57 = write, 0x52 = read; any other CMD SHALL queue error byte 0x3F and return to IDLE without touching the bus.
REQ-005 States SHALL be IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, BUS_WAIT, BUS_ACC, TX_HI, TX_LO; each byte-collect state advances only on i_rxValid.
REQ-006 After the last frame byte, the FSM SHALL enter BUS_WAIT and assert o_busReq until the access cycle completes.
REQ-007 In BUS_WAIT, on the first cycle with i_busGrant=1 the FSM SHALL move to BUS_ACC the next cycle.
REQ-008 BUS_ACC SHALL last exactly one cycle with o_memAddr valid and exactly one of o_memWrEn/o_memRdEn high; o_memDataOut valid for writes.
REQ-009 Reads: i_memDataIn SHALL be captured at the end of the BUS_ACC cycle.
REQ-010 Outside BUS_ACC, o_memWrEn=o_memRdEn=0; o_memAddr and o_memDataOut hold last values.
REQ-011 o_busReq SHALL drop the cycle after BUS_ACC.
REQ-012 Write response: single byte 0x4B (TX_LO only); read response: captured[15:8] in TX_HI then captured[7:0] in TX_LO.
REQ-013 o_txValid SHALL stay high with o_txByte stable until i_txReady=1; a byte is consumed on the edge where both are high; after TX_LO consumed -> IDLE.
REQ-014 i_rxValid in BUS_WAIT, BUS_ACC, TX_HI or TX_LO SHALL be dropped (no buffering).
REQ-015 Timeout: a 16-bit counter clears on every i_rxValid and on entering ADDR_HI; if it reaches TIMEOUT while in ADDR_HI..DATA_LO, the FSM SHALL return to IDLE silently (no response).
REQ-016 Timeout SHALL NOT apply in BUS_WAIT or TX states; the bridge waits indefinitely for grant/ready.
REQ-017 If i_rxValid and timeout occur in the same cycle, the byte wins (counter clears, state advances).

Reset
REQ-018 On i_rstn=0, immediately: state=IDLE, o_txValid=0, o_txByte=0, o_busReq=0, o_memWrEn=0, o_memRdEn=0, o_memAddr=0, o_memDataOut=0, o_busy=0, counter=0, captured data=0.
REQ-019 Reset mid-frame or mid-access SHALL abandon the frame with no bus strobe or response after release.

Structure
REQ-020 A shared package SHALL hold the state encoding and constants CMD_WR=0x57, CMD_RD=0x52, RSP_ACK=0x4B, RSP_ERR=0x3F.
REQ-021 One sub-module, byte_timeout_counter (clear, enable, TIMEOUT compare, expired flag), is natural; the rest is flat FSM plus registers.

Verification
REQ-022 Bytes 0x57,0x00,0x04,0xAB,0xCD, grant immediate -> one cycle o_memWrEn=1, o_memAddr=0x0004, o_memDataOut=0xABCD; then tx 0x4B.
REQ-023 Bytes 0x52,0xC0,0x10, responder returns 0x1234, grant delayed 5 cycles -> o_busReq high 6 cycles, one o_memRdEn, tx 0x12 then 0x34; address 0x0010 (ADDR_HI[7:6] ignored).
REQ-024 Byte 0x41 -> tx 0x3F, no bus strobe, o_busReq never high.
REQ-025 Bytes 0x57,0x00 then TIMEOUT idle cycles -> o_busy falls, no tx; next frame 0x52,0x00,0x00 executes normally.
REQ-026 Read response with i_txReady low 10 cycles -> o_txByte held stable; extra i_rxValid during TX dropped.
REQ-027 Assert i_rstn=0 while in BUS_WAIT -> all outputs zero asynchronously; after release no strobe, no tx.
